// File: rtl/cla_serial_sched.sv
// Nibble-serial adder shared by two requesters. One 4-bit carry-lookahead
// slice is reused over WIDTH/4 cycles; a round-robin arbiter picks the
// requester and the result is held until the consumer takes it.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  assign g  = a & b;
  assign p  = a ^ b;
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ {c3, c2, c1, cin};
  assign cout = c4;
endmodule

module cla_serial_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [KW-1:0]    k;
  logic             carry;
  logic             id_reg;
  logic             rr_ptr;
  logic             grant;
  logic             accept;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] slice_ext;

  // Pick the requester to offer ready to: a lone valid wins, a tie goes to rr_ptr.
  always_comb begin
    grant = rr_ptr;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && !rst && (grant == 1'b0);
  assign req1_ready = (state == IDLE) && !rst && (grant == 1'b1);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Operands shift right one nibble per ADD cycle, so the slice always sees bits [3:0].
  cla4 u_slice (
    .a    (a_reg[3:0]),
    .b    (b_reg[3:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign slice_ext = WIDTH'(slice_sum);
  assign rsp_sum   = sum_reg;

  // Control FSM: capture on acceptance, one nibble per ADD cycle, hold result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      k         <= '0;
      carry     <= 1'b0;
      id_reg    <= 1'b0;
      rr_ptr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg  <= grant ? req1_a : req0_a;
            b_reg  <= grant ? req1_b : req0_b;
            carry  <= grant ? req1_cin : req0_cin;
            id_reg <= grant;
            rr_ptr <= ~grant;
            k      <= '0;
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          sum_reg <= (sum_reg >> 4) | (slice_ext << (WIDTH - 4));
          a_reg   <= a_reg >> 4;
          b_reg   <= b_reg >> 4;
          carry   <= slice_cout;
          k       <= k + KW'(1);
          if (k == KLAST) begin
            rsp_valid <= 1'b1;
            rsp_cout  <= slice_cout;
            rsp_id    <= id_reg;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
